// File: rtl/trisc_mem_responder.sv
// trisc_mem_responder: 16x8 program/data store with edge-qualified requests, fixed wait states and a preload port
module trisc_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int WAIT = 2
) (
  input  logic              SysClock,
  input  logic              StartStop,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdReq,
  input  logic              WrReq,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic [DATA_W-1:0] RdData,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);
  typedef enum logic [2:0] {IDLE, RWAIT, RDONE, WWAIT, WDONE} state_t;
  state_t state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_wa;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_wd;
  logic ready_q, ready_d, busy_q, busy_d, err_q, err_d, rd_prev_q, wr_prev_q, mem_we;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic rd_rise, wr_rise;
  assign rd_rise = RdReq & ~rd_prev_q;
  assign wr_rise = WrReq & ~wr_prev_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d = busy_q;
    err_d = LoadEn;
    mem_we = 1'b0;
    mem_wa = addr_q;
    mem_wd = wdata_q;
    case (state_q)
      IDLE: begin
        if (rd_rise && wr_rise) begin
          err_d = 1'b1;
        end else if (rd_rise || wr_rise) begin
          state_d = rd_rise ? RWAIT : WWAIT;
          count_d = 3'(WAIT);
          addr_d = Addr;
          wdata_d = WrData;
          busy_d = 1'b1;
        end else begin
          err_d = 1'b0;
          mem_we = LoadEn;
          mem_wa = LoadAddr;
          mem_wd = LoadData;
        end
      end
      RWAIT, WWAIT: begin
        count_d = count_q - 3'd1;
        if (count_q == 3'd1) begin
          state_d = (state_q == RWAIT) ? RDONE : WDONE;
          ready_d = 1'b1;
          rdata_d = (state_q == RWAIT) ? mem[addr_q] : rdata_q;
          mem_we = (state_q == WWAIT);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(negedge SysClock or posedge StartStop) begin
    if (StartStop) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      err_q <= err_d;
      rd_prev_q <= RdReq;
      wr_prev_q <= WrReq;
    end
  end
  always_ff @(negedge SysClock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  assign RdData = rdata_q;
  assign Ready = ready_q;
  assign Busy = busy_q;
  assign Err = err_q;
endmodule

// File: doc/trisc_mem_responder.md
Name: trisc_mem_responder

Overview:
- Memory-side responder for the TRISC controller's memory interface: 16-word x 8-bit program/data store.
- Services read requests (controller's fetch/operand-read strobe) and write requests (store strobe) with a fixed, parameterised number of wait states and a one-cycle Ready pulse.
- Sits between the controller/datapath (MAR, accumulator) and the instruction/data bus.
- Side-band load port preloads programs while the responder is idle.

Parameters:
- DATA_W, 8, data word width (4-bit opcode + 4-bit address).
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- WAIT, 2, wait states from request acceptance to Ready; legal range 1..7.

Ports:
- SysClock  in  1  system clock; all state updates on falling edge.
- StartStop  in  1  asynchronous, active-high reset.
- Addr  in  ADDR_W  access address, latched at request acceptance.
- WrData  in  DATA_W  write data, latched at request acceptance.
- RdReq  in  1  read request, level; held by requester.
- WrReq  in  1  write request, level; held by requester.
- LoadEn  in  1  preload strobe.
- LoadAddr  in  ADDR_W  preload address.
- LoadData  in  DATA_W  preload data.
- RdData  out  DATA_W  read data; valid while Ready=1, held afterwards.
- Ready  out  1  one-cycle completion pulse, read or write.
- Busy  out  1  high from acceptance through DONE.
- Err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (StartStop=1, asynchronous): state=IDLE, count=0, RdData=0, Ready=0, Busy=0, Err=0, previous-request registers=0.
- Reset does not clear memory contents.
- Reset mid-transaction aborts the transaction. A write aborted before WDONE does not modify memory.
- States: IDLE, RWAIT, RDONE, WWAIT, WDONE. Outputs Ready, Busy and Err are registered.
- Request acceptance is edge-qualified. A request is accepted only on a falling edge where the state is IDLE, the request is 1, and its registered previous value is 0. A request held across DONE is therefore not re-accepted; the requester must drop it for at least one cycle.
- Acceptance edge:
  - Latch Addr and WrData.
  - Load count=WAIT.
  - Busy=1.
  - Go to RWAIT (read) or WWAIT (write).
- RWAIT/WWAIT: decrement count each edge. On the edge where count==1, go to RDONE/WDONE.
  - Ready rises exactly WAIT edges after the acceptance edge.
- RDONE: Ready=1, RdData=mem[latched addr]. Next edge: IDLE, Ready=0, Busy=0. RdData holds its value until the next read completes.
- WDONE: mem[latched addr] is written on the edge entering WDONE, and Ready=1. Next edge: IDLE, Busy=0.
- Read-after-write to the same address returns the new value.
- Changes to Addr/WrData after acceptance are ignored.
- A request deasserted during WAIT does not abort: the transaction completes and Ready still pulses.
- Simultaneous RdReq and WrReq rising in IDLE: no access, Err=1 for one cycle, state stays IDLE.
- Request edges arriving while Busy are ignored. No queueing, no Err.
- Load port:
  - In IDLE with no accepted request, LoadEn=1 writes LoadData to mem[LoadAddr] on that edge. Ready is not affected.
  - LoadEn=1 while Busy: ignored, Err=1 for one cycle.
  - LoadEn=1 in the same IDLE edge as an accepted request: the request wins, the load is dropped, Err=1 for one cycle.
- Address wrap: none needed; Addr is exactly ADDR_W bits and covers the full depth.

Test Plan (WAIT=2 unless stated):
- Preload mem[3]=8'hA5 via LoadEn; raise RdReq with Addr=3 at edge e0 -> Busy=1 after e0; Ready=1 and RdData=8'hA5 after e2; Ready=0, Busy=0 after e3.
- WrReq with Addr=5, WrData=8'h3C; change Addr to 9 at e1 -> mem[5]=8'h3C after e2, mem[9] unchanged; a following read of 5 returns 8'h3C.
- Hold RdReq high for 6 cycles -> exactly one Ready pulse; after dropping and re-raising RdReq, a second pulse appears 2 edges after re-acceptance.
- RdReq and WrReq rising on the same edge in IDLE -> Err pulses one cycle, Busy stays 0, memory unchanged.
- Assert StartStop at e1 of a write to address 7 (old value 8'h11) -> all outputs 0 immediately; mem[7] still 8'h11; the next read works normally.
- WAIT=5 build: read request -> Ready exactly 5 edges after acceptance. LoadEn while Busy -> Err pulse, target word unchanged.
